// File: rtl/cache_flush_pkg.sv
// Shared types and width helpers for the cache flush controller.
// The state encoding is fixed so waveforms and debug probes stay readable.
package cache_flush_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CHECK   = 3'd2,
      WB_REQ  = 3'd3,
      WB_WAIT = 3'd4,
      CLEAR   = 3'd5,
      DONE    = 3'd6
   } flush_state_t;

   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction

   // Byte offset within a line of 32-bit words.
   function automatic int off_w(input int words_per_line);
      return $clog2(words_per_line * 4);
   endfunction

   function automatic int tag_w(input int addr_width, input int num_lines,
                                input int words_per_line);
      return addr_width - idx_w(num_lines) - off_w(words_per_line);
   endfunction

endpackage

// File: rtl/cache_flush_ctrl.sv
// Walks every cache line on a flush request, writes back valid+dirty lines,
// invalidates all lines and pulses flush_done; stalls the core while busy.
module cache_flush_ctrl
   import cache_flush_pkg::*;
#(
   parameter  int NUM_LINES      = 8,
   parameter  int WORDS_PER_LINE = 16,
   parameter  int ADDR_WIDTH     = 32,
   localparam int IDX_W          = idx_w(NUM_LINES),
   localparam int OFF_W          = off_w(WORDS_PER_LINE),
   localparam int TAG_W          = tag_w(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_req,
   output logic [IDX_W-1:0]      line_idx,
   input  logic                  line_valid,
   input  logic                  line_dirty,
   input  logic [TAG_W-1:0]      line_tag,
   output logic                  wb_req_valid,
   input  logic                  wb_req_ready,
   output logic [ADDR_WIDTH-1:0] wb_req_addr,
   output logic [IDX_W-1:0]      wb_req_idx,
   input  logic                  wb_done,
   output logic                  clr_en,
   output logic [IDX_W-1:0]      clr_idx,
   output logic                  flush_busy,
   output logic                  flush_done
);

   localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

   flush_state_t            state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic                    pending_q, pending_d;
   logic                    req_q;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [IDX_W-1:0]        wb_idx_q, wb_idx_d;
   logic                    req_edge;

   assign req_edge = flush_req & ~req_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      addr_d    = addr_q;
      wb_idx_d  = wb_idx_q;

      unique case (state_q)
         IDLE: begin
            if (req_edge) begin
               state_d = READ;
               cnt_d   = '0;
            end
         end
         READ:  state_d = CHECK;
         CHECK: begin
            if (line_valid && line_dirty) begin
               state_d  = WB_REQ;
               addr_d   = {line_tag, cnt_q, {OFF_W{1'b0}}};
               wb_idx_d = cnt_q;
            end else begin
               state_d = CLEAR;
            end
         end
         WB_REQ: begin
            if (wb_req_ready) state_d = WB_WAIT;
         end
         // A wb_done coinciding with the handshake is seen in WB_REQ and dropped.
         WB_WAIT: begin
            if (wb_done) state_d = CLEAR;
         end
         CLEAR: begin
            if (cnt_q == LAST_LINE) begin
               state_d = DONE;
            end else begin
               state_d = READ;
               cnt_d   = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            // An edge landing in DONE itself is treated like a pending request.
            if (pending_q || req_edge) begin
               state_d   = READ;
               cnt_d     = '0;
               pending_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (req_edge && (state_q != IDLE) && (state_q != DONE)) pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= '0;
         wb_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         req_q     <= flush_req;
         addr_q    <= addr_d;
         wb_idx_q  <= wb_idx_d;
      end
   end

   assign line_idx     = cnt_q;
   assign wb_req_valid = (state_q == WB_REQ);
   assign wb_req_addr  = addr_q;
   assign wb_req_idx   = wb_idx_q;
   assign clr_en       = (state_q == CLEAR);
   assign clr_idx      = clr_en ? cnt_q : '0;
   assign flush_busy   = (state_q != IDLE);
   assign flush_done   = (state_q == DONE);

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed self-checking bench for cache_flush_ctrl with a registered
// tag/valid/dirty array model and an optional auto write-back responder.
module tb_cache_flush_ctrl;

   localparam int NUM_LINES      = 8;
   localparam int WORDS_PER_LINE = 16;
   localparam int ADDR_WIDTH     = 32;
   localparam int IDX_W          = 3;
   localparam int TAG_W          = 23;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush_req;
   logic [IDX_W-1:0]      line_idx;
   logic                  line_valid;
   logic                  line_dirty;
   logic [TAG_W-1:0]      line_tag;
   logic                  wb_req_valid;
   logic                  wb_req_ready;
   logic [ADDR_WIDTH-1:0] wb_req_addr;
   logic [IDX_W-1:0]      wb_req_idx;
   logic                  wb_done;
   logic                  clr_en;
   logic [IDX_W-1:0]      clr_idx;
   logic                  flush_busy;
   logic                  flush_done;

   cache_flush_ctrl #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .ADDR_WIDTH     (ADDR_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_req    (flush_req),
      .line_idx     (line_idx),
      .line_valid   (line_valid),
      .line_dirty   (line_dirty),
      .line_tag     (line_tag),
      .wb_req_valid (wb_req_valid),
      .wb_req_ready (wb_req_ready),
      .wb_req_addr  (wb_req_addr),
      .wb_req_idx   (wb_req_idx),
      .wb_done      (wb_done),
      .clr_en       (clr_en),
      .clr_idx      (clr_idx),
      .flush_busy   (flush_busy),
      .flush_done   (flush_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Cache array model: one-cycle registered read, cleared by clr_en.
   logic             m_valid [NUM_LINES];
   logic             m_dirty [NUM_LINES];
   logic [TAG_W-1:0] m_tag   [NUM_LINES];
   logic             cfg_valid [NUM_LINES];
   logic             cfg_dirty [NUM_LINES];
   logic [TAG_W-1:0] cfg_tag   [NUM_LINES];
   logic             load_req;

   always @(posedge clk) begin
      line_valid <= m_valid[line_idx];
      line_dirty <= m_dirty[line_idx];
      line_tag   <= m_tag[line_idx];
      if (load_req) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] <= cfg_valid[i];
            m_dirty[i] <= cfg_dirty[i];
            m_tag[i]   <= cfg_tag[i];
         end
      end else if (clr_en) begin
         m_valid[clr_idx] <= 1'b0;
         m_dirty[clr_idx] <= 1'b0;
      end
   end

   // Write-back port: manual controls plus auto mode (ready=1, done 2 cycles after handshake).
   logic man_ready, man_done, auto_en, auto_done;
   int   auto_cd = 0;

   assign wb_req_ready = man_ready | auto_en;
   assign wb_done      = man_done | auto_done;

   always @(negedge clk) begin
      auto_done = 1'b0;
      if (auto_cd > 0) begin
         auto_cd = auto_cd - 1;
         if (auto_cd == 0) auto_done = 1'b1;
      end
      if (auto_en && wb_req_valid && wb_req_ready) auto_cd = 2;
   end

   // Output monitor, sampled on the falling edge.
   int                    clr_log  [$];
   int                    wb_idx_log [$];
   logic [ADDR_WIDTH-1:0] wb_addr_log [$];
   int                    done_cnt = 0;
   int                    valid_cycles = 0;

   always @(negedge clk) begin
      if (clr_en) clr_log.push_back(int'(clr_idx));
      if (wb_req_valid && wb_req_ready) begin
         wb_idx_log.push_back(int'(wb_req_idx));
         wb_addr_log.push_back(wb_req_addr);
      end
      if (flush_done) done_cnt++;
      if (wb_req_valid) valid_cycles++;
   end

   int clr_base, wb_base, done_base, valid_base;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      clr_base   = clr_log.size();
      wb_base    = wb_idx_log.size();
      done_base  = done_cnt;
      valid_base = valid_cycles;
   endtask

   task automatic load(input logic [NUM_LINES-1:0] v, input logic [NUM_LINES-1:0] d,
                       input logic [TAG_W-1:0] tag_base);
      for (int i = 0; i < NUM_LINES; i++) begin
         cfg_valid[i] = v[i];
         cfg_dirty[i] = d[i];
         cfg_tag[i]   = tag_base + TAG_W'(i);
      end
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
   endtask

   // Returns number of rising edges until flush_done is seen (bounded).
   task automatic wait_done(input int budget, input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!flush_done && n < budget);
      check(tag, flush_done, 1'b1);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wb_req_valid && n < budget);
      check(tag, wb_req_valid, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  flush_busy, 1'b0);
      check({tag, "_done"},  flush_done, 1'b0);
      check({tag, "_wbv"},   wb_req_valid, 1'b0);
      check({tag, "_addr"},  wb_req_addr, '0);
      check({tag, "_wbidx"}, wb_req_idx, '0);
      check({tag, "_clren"}, clr_en, 1'b0);
      check({tag, "_clridx"}, clr_idx, '0);
      check({tag, "_lidx"},  line_idx, '0);
   endtask

   initial begin
      int n;
      int k;
      logic [ADDR_WIDTH-1:0] exp_addr;

      rst       = 1'b1;
      flush_req = 1'b0;
      man_ready = 1'b0;
      man_done  = 1'b0;
      auto_en   = 1'b0;
      load_req  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // 1: all lines clean -> 8 clears, no write-back, done 25 cycles after the edge.
      load(8'hA5, 8'h00, 23'h0);
      mark();
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      check("t1_busy_next", flush_busy, 1'b1);
      wait_done(60, "t1_done_seen", n);
      check("t1_latency", n + 1, 25);
      @(posedge clk);
      #1;
      check("t1_busy_after", flush_busy, 1'b0);
      check("t1_clr_count", clr_log.size() - clr_base, 8);
      for (int i = 0; i < NUM_LINES; i++) check("t1_clr_order", clr_log[clr_base + i], i);
      check("t1_no_wb", valid_cycles - valid_base, 0);
      check("t1_done_count", done_cnt - done_base, 1);
      flush_req = 1'b0;

      // 2: line 3 dirty, tag 0x1234; ready held low, late wb_done.
      load(8'h08, 8'h08, 23'h1231);
      mark();
      flush_req = 1'b1;
      wait_valid(60, "t2_valid_seen");
      check("t2_addr", wb_req_addr, 32'h0024_68C0);
      check("t2_idx", wb_req_idx, 3);
      check("t2_clr_before", clr_log.size() - clr_base, 3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("t2_hold_valid", wb_req_valid, 1'b1);
         check("t2_hold_addr", wb_req_addr, 32'h0024_68C0);
      end
      man_ready = 1'b1;
      man_done  = 1'b1;   // coincides with the handshake, must be ignored
      @(posedge clk);
      #1;
      man_ready = 1'b0;
      man_done  = 1'b0;
      check("t2_valid_dropped", wb_req_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("t2_no_clr_in_wait", clr_log.size() - clr_base, 3);
      man_done = 1'b1;
      @(posedge clk);
      #1;
      man_done = 1'b0;
      check("t2_clr_en", clr_en, 1'b1);
      check("t2_clr_idx", clr_idx, 3);
      wait_done(40, "t2_done_seen", n);
      check("t2_clr_count", clr_log.size() - clr_base, 8);
      check("t2_wb_count", wb_idx_log.size() - wb_base, 1);
      flush_req = 1'b0;

      // 3: all dirty, line 5 invalid; auto responder.
      load(8'hDF, 8'hFF, 23'h100);
      mark();
      auto_en   = 1'b1;
      flush_req = 1'b1;
      wait_done(300, "t3_done_seen", n);
      check("t3_wb_count", wb_idx_log.size() - wb_base, 7);
      k = 0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (i != 5) begin
            exp_addr = ((32'h100 + 32'(i)) << 9) | (32'(i) << 6);
            check("t3_wb_idx", wb_idx_log[wb_base + k], i);
            check("t3_wb_addr", wb_addr_log[wb_base + k], exp_addr);
            k++;
         end
      end
      @(posedge clk);
      #1;
      check("t3_done_count", done_cnt - done_base, 1);
      auto_en   = 1'b0;
      flush_req = 1'b0;

      // 4a: second edge while busy -> second walk from line 0, 25 cycles after first done.
      load(8'h00, 8'h00, 23'h0);
      mark();
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) @(posedge clk);
      #1;
      flush_req = 1'b0;
      @(posedge clk);
      #1;
      flush_req = 1'b1;
      wait_done(60, "t4_first_done", n);
      wait_done(60, "t4_second_done", n);
      check("t4_gap", n, 25);
      check("t4_clr_count", clr_log.size() - clr_base, 16);
      check("t4_restart_line0", clr_log[clr_base + 8], 0);
      @(posedge clk);
      #1;
      check("t4_idle_after", flush_busy, 1'b0);
      flush_req = 1'b0;
      @(posedge clk);
      #1;

      // 4b: three edges while busy merge into a single pending walk.
      mark();
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         flush_req = 1'b0;
         @(posedge clk);
         #1;
         flush_req = 1'b1;
      end
      flush_req = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check("t4b_done_count", done_cnt - done_base, 2);
      check("t4b_clr_count", clr_log.size() - clr_base, 16);

      // 5: level held high for 50 cycles -> one walk.
      mark();
      flush_req = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      flush_req = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("t5_done_count", done_cnt - done_base, 1);
      check("t5_clr_count", clr_log.size() - clr_base, 8);
      check("t5_idle", flush_busy, 1'b0);

      // 6: reset in WB_WAIT aborts; then a fresh walk completes.
      load(8'h04, 8'h04, 23'h0);
      mark();
      flush_req = 1'b1;
      wait_valid(60, "t6_valid_seen");
      flush_req = 1'b0;
      man_ready = 1'b1;
      @(posedge clk);
      #1;
      man_ready = 1'b0;
      check("t6_in_wait", wb_req_valid, 1'b0);
      check("t6_busy_wait", flush_busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("t6_rst");
      repeat (10) @(posedge clk);
      #1;
      check("t6_no_done", done_cnt - done_base, 0);
      check("t6_idle", flush_busy, 1'b0);
      mark();
      auto_en   = 1'b1;
      flush_req = 1'b1;
      wait_done(200, "t6_walk_done", n);
      check("t6_wb_count", wb_idx_log.size() - wb_base, 1);
      check("t6_wb_idx", wb_idx_log[wb_base], 2);
      check("t6_wb_addr", wb_addr_log[wb_base], 32'h0000_0480);
      check("t6_clr_count", clr_log.size() - clr_base, 8);
      auto_en   = 1'b0;
      flush_req = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
